// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic pipeline: op encodings and op type.
package logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND   = 3'b000;
    localparam op_t OP_XOR   = 3'b001;
    localparam op_t OP_OR    = 3'b010;
    localparam op_t OP_NOTB  = 3'b011;
    localparam op_t OP_NAND  = 3'b100;
    localparam op_t OP_NOR   = 3'b101;
    localparam op_t OP_XNOR  = 3'b110;
    localparam op_t OP_PASSA = 3'b111;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation unit; purely per-bit, no carries or sign handling.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    output logic [N-1:0] R
);

    always_comb begin
        R = A;
        case (op)
            OP_AND:   R = A & B;
            OP_XOR:   R = A ^ B;
            OP_OR:    R = A | B;
            OP_NOTB:  R = ~B;
            OP_NAND:  R = ~(A & B);
            OP_NOR:   R = ~(A | B);
            OP_XNOR:  R = ~(A ^ B);
            OP_PASSA: R = A;
            default:  R = A;
        endcase
    end

endmodule

// File: rtl/logic_pipe.sv
// Valid/ready pipeline around logic_op_core: op evaluated into stage 1, result
// carried through STAGES registers, zero/parity derived from the last stage.
module logic_pipe
    import logic_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] RL,
    output logic         zero,
    output logic         parity
);

    logic [N-1:0]             r_op;
    logic [STAGES:1]          vld_pipe;
    logic [STAGES:1][N-1:0]   dat_pipe;
    logic [STAGES:1]          en;
    logic                     rdy_en;
    logic                     accept;

    logic_op_core #(.N(N)) u_core (
        .A  (A),
        .B  (B),
        .op (op),
        .R  (r_op)
    );

    // A stage may load when it, or any stage after it, has a hole, or the sink drains.
    always_comb begin
        logic acc;
        acc = out_ready;
        en  = '0;
        for (int s = STAGES; s >= 1; s--) begin
            acc   = acc | ~vld_pipe[s];
            en[s] = acc;
        end
    end

    // rdy_en keeps in_ready low through reset and until the first edge after release.
    assign in_ready = rdy_en & en[1];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en   <= 1'b0;
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (en[1]) begin
                vld_pipe[1] <= accept;
                if (accept)
                    dat_pipe[1] <= r_op;
            end
            for (int s = 2; s <= STAGES; s++) begin
                if (en[s]) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    if (vld_pipe[s-1])
                        dat_pipe[s] <= dat_pipe[s-1];
                end
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign RL        = dat_pipe[STAGES];
    assign zero      = ~|RL;
    assign parity    = ^RL;

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: directed vectors push expected results,
// per-instance monitors pop and compare whenever a result is presented.
module tb_logic_pipe;

    typedef struct {
        logic [15:0] rl;
        logic        zero;
        logic        parity;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, zero, parity;
    logic [7:0] a, b, rl;
    logic [2:0] op;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, parity16;
    logic [15:0] a16, b16, rl16;
    logic [2:0]  op16;

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAA, 8'hAF, 8'hF0, 8'hFA, 8'h50, 8'h55, 8'hA5};
    logic [2:0] bp_op     [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
    logic [7:0] bp_exp    [4] = '{8'h05, 8'hAA, 8'h55, 8'hA5};

    logic_pipe u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .RL(rl), .zero(zero), .parity(parity)
    );

    logic_pipe #(.N(16), .STAGES(3)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .RL(rl16), .zero(zero16), .parity(parity16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors sample mid-low-phase, after the drivers have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out8_unexpected got %h expected none", rl);
                end else begin
                    e = q8[0];
                    chk("rl8", {8'h00, rl}, e.rl);
                    chk("zero8", {15'h0, zero}, {15'h0, e.zero});
                    chk("parity8", {15'h0, parity}, {15'h0, e.parity});
                    if (out_ready) void'(q8.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid16) begin
                if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out16_unexpected got %h expected none", rl16);
                end else begin
                    e = q16[0];
                    chk("rl16", rl16, e.rl);
                    chk("zero16", {15'h0, zero16}, {15'h0, e.zero});
                    chk("parity16", {15'h0, parity16}, {15'h0, e.parity});
                    if (out_ready16) void'(q16.pop_front());
                end
            end
        end
    end

    task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                         input bit push, input logic [7:0] erl, input logic ez, input logic ep);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout got in_ready 0 expected 1");
        end else if (push) begin
            e.rl = {8'h00, erl}; e.zero = ez; e.parity = ep;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    endtask

    task automatic send16(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] iop,
                          input logic [15:0] erl, input logic ez, input logic ep);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        a16 = ia; b16 = ib; op16 = iop; in_valid16 = 1'b1;
        #1;
        while (!in_ready16 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready16) begin
            checks++;
            errors++;
            $display("FAIL send16_timeout got in_ready 0 expected 1");
        end else begin
            e.rl = erl; e.zero = ez; e.parity = ep;
            q16.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); op16 = 3'($urandom);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q8.size() != 0 || q16.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        #3;
        chk(name, 16'(q8.size() + q16.size()), 16'd0);
    endtask

    initial begin
        int idx;
        int c_first;
        int c_last;
        in_valid = 0; out_ready = 1; a = 0; b = 0; op = 0;
        in_valid16 = 0; out_ready16 = 1; a16 = 0; b16 = 0; op16 = 0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", {15'h0, out_valid}, 16'd0);
        chk("rst_rl", {8'h00, rl}, 16'h0000);
        chk("rst_zero", {15'h0, zero}, 16'd1);
        chk("rst_parity", {15'h0, parity}, 16'd0);
        chk("rst_in_ready", {15'h0, in_ready}, 16'd0);
        repeat (2) @(posedge clk);
        #1 chk("rst_in_ready_held", {15'h0, in_ready}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_before_edge", {15'h0, in_ready}, 16'd0);
        @(posedge clk);
        #1 chk("in_ready_after_edge", {15'h0, in_ready}, 16'd1);

        // Single op and latency
        send8(8'hF0, 8'h3C, 3'd0, 1, 8'h30, 0, 0);
        chk("lat8_early", {15'h0, out_valid}, 16'd0);
        @(posedge clk);
        #1 chk("lat8_valid", {15'h0, out_valid}, 16'd1);
        drain("drain_single");

        // Full sweep, back-to-back
        for (int i = 0; i < 8; i++) begin
            send8(8'hA5, 8'h0F, 3'(i), 1, sweep_exp[i], 0, 0);
            if (i == 0) c_first = cyc;
            if (i == 7) c_last = cyc;
        end
        chk("sweep_cycles", 16'(c_last - c_first), 16'd7);
        drain("drain_sweep");

        // Zero and parity
        send8(8'h55, 8'h55, 3'd1, 1, 8'h00, 1, 0);
        send8(8'h01, 8'h00, 3'd2, 1, 8'h01, 0, 1);
        send8(8'h07, 8'h00, 3'd1, 1, 8'h07, 0, 1);
        drain("drain_flags");

        // Backpressure
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (idx < 4) begin
                a = 8'hA5; b = 8'h0F; op = bp_op[idx]; in_valid = 1'b1;
            end
            #1;
            if (in_valid && in_ready) begin
                q8.push_back('{rl: {8'h00, bp_exp[idx]}, zero: 1'b0, parity: 1'b0});
                idx++;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        chk("bp_accepts", 16'(idx), 16'd2);
        chk("bp_in_ready", {15'h0, in_ready}, 16'd0);
        chk("bp_out_valid", {15'h0, out_valid}, 16'd1);
        @(negedge clk);
        out_ready = 1'b1;
        while (idx < 4) begin
            send8(8'hA5, 8'h0F, bp_op[idx], 1, bp_exp[idx], 0, 0);
            idx++;
        end
        drain("drain_bp");

        // Reset mid-flight: these two results must never appear
        send8(8'hF0, 8'h3C, 3'd0, 0, 8'h00, 0, 0);
        send8(8'h12, 8'h34, 3'd1, 0, 8'h00, 0, 0);
        chk("mid_out_valid_pre", {15'h0, out_valid}, 16'd1);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", {15'h0, out_valid}, 16'd0);
        chk("mid_rl", {8'h00, rl}, 16'h0000);
        chk("mid_zero", {15'h0, zero}, 16'd1);
        chk("mid_in_ready", {15'h0, in_ready}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("mid_no_stale", {15'h0, out_valid}, 16'd0);

        // Wide, deeper instance
        send16(16'hFFFF, 16'h00FF, 3'd4, 16'hFF00, 0, 0);
        chk("lat16_c1", {15'h0, out_valid16}, 16'd0);
        @(posedge clk);
        #1 chk("lat16_c2", {15'h0, out_valid16}, 16'd0);
        @(posedge clk);
        #1 chk("lat16_c3", {15'h0, out_valid16}, 16'd1);
        send16(16'h1234, 16'h00FF, 3'd1, 16'h12CB, 0, 1);
        drain("drain_16");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
